div_unit: RTL



---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module : div_unit_pkg
// Desc   : Shared divider constants and FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  localparam int DIV_ITER = 32;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Desc   : One restoring shift-subtract iteration on unsigned magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The partial remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH+1
  // bits hold both the shifted remainder and a valid sign for the trial.
  assign w_shift = {rem_in, quo_in[WIDTH-1]};
  assign w_trial = w_shift - dvs;

  assign rem_out = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Desc   : Multi-cycle signed divider (DIV): hi = remainder, lo = quotient.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV_ITER - 1);

  div_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo;
  logic [WIDTH:0]   r_dvs;
  logic             r_sign_q, r_sign_r;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_div_zero;

  logic             w_accept, w_zero;
  logic [WIDTH:0]   w_ds_ext, w_ds_mag;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;

  assign w_accept = (r_state == DIV_IDLE) && start;
  assign w_zero   = (divisor == '0);

  // Unsigned WIDTH-bit negation of the most negative dividend yields 2^(WIDTH-1)
  // exactly; the divisor needs WIDTH+1 bits to be subtracted directly.
  assign w_dd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign w_ds_ext = {divisor[WIDTH-1], divisor};
  assign w_ds_mag = divisor[WIDTH-1] ? (~w_ds_ext + (WIDTH+1)'(1)) : w_ds_ext;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .dvs     (r_dvs),
    .rem_out (w_rem_nxt),
    .quo_out (w_quo_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (start && !w_zero) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (r_cnt == c_last)  w_state_nxt = DIV_FIX;
      DIV_FIX:  w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= DIV_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div_zero <= w_accept && w_zero;
      if (w_accept && !w_zero) begin
        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_sign_r <= dividend[WIDTH-1];
        r_quo    <= w_dd_mag;
        r_dvs    <= w_ds_mag;
        r_rem    <= '0;
        r_cnt    <= '0;
      end
      if (r_state == DIV_RUN) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Truncating division: quotient sign from XOR, remainder follows dividend.
      if (r_state == DIV_FIX) begin
        r_lo <= r_sign_q ? (~r_quo + WIDTH'(1)) : r_quo;
        r_hi <= r_sign_r ? (~r_rem + WIDTH'(1)) : r_rem;
      end
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state == DIV_RUN) || (r_state == DIV_FIX);
  assign done     = (r_state == DIV_DONE);
  assign div_zero = r_div_zero;

endmodule

`default_nettype wire
